data_memory_arbiter: RTL and testbench
======================================

# data_memory_arbiter

Two-port arbiter that shares the single-port data memory between two requesters, e.g. the load/store stage (port 0) and a program/debug loader (port 1). Accepts at most one access per arbitration, drives the memory's address, write-data and enable inputs from registered copies of the winning request, captures read data, and returns a per-port response pulse. Sits between the requesters and the data memory unit. It is the only driver of the memory's inputs.

## Interface
- No parameters. Widths are fixed: 16-bit address, 16-bit data.
- `clk` input 1: single clock; all state updates on rising edge.
- `reset` input 1: synchronous, active-high.
- `req0`, `req1` input 1: access request, held high until the matching `gnt` is seen.
- `we0`, `we1` input 1: 1 = write, 0 = read; held stable with `req`.
- `addr0`, `addr1` input 16: word address; held stable with `req`.
- `wdata0`, `wdata1` input 16: write data; held stable with `req`.
- `gnt0`, `gnt1` output 1: one-cycle pulse; request accepted and issued to memory this cycle.
- `rvalid0`, `rvalid1` output 1: one-cycle response pulse for both reads and writes.
- `rdata0`, `rdata1` output 16: read data, valid while the matching `rvalid` is high; 0 for writes.
- `mem_address` output 16: memory address.
- `mem_write_data` output 16: memory write data.
- `mem_write_enable` output 1: memory write strobe.
- `mem_read_enable` output 1: memory read enable.
- `mem_read_data` input 16: combinational read data from memory.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- **IDLE**
  - No request: stay in IDLE.
  - Any `req` high: select a winner; latch its `we`/`addr`/`wdata` and its port id into `*_q` registers; go to ACCESS.
- **ACCESS**
  - `gnt` of the winner = 1.
  - `mem_address` = `addr_q`; `mem_write_data` = `wdata_q`.
  - `mem_write_enable` = `we_q & ~reset`; `mem_read_enable` = `~we_q`.
  - On a read, `mem_read_data` is captured into `rdata_q`. On a write, `rdata_q` is cleared to 0.
  - Next state is always RESP.
- **RESP**
  - The winner's `rvalid` = 1 and its `rdata` = `rdata_q`.
  - Arbitration happens again in this cycle, using the same rules as IDLE.
  - Any `req` high: latch the new winner and go to ACCESS. Otherwise go to IDLE.
- **Arbitration**: round-robin on a 1-bit `last` register.
  - Only one `req` high: that port wins.
  - Both high: the port not equal to `last` wins.
  - `last` updates to the winner whenever a winner is latched.
- Outside ACCESS:
  - `mem_write_enable` = 0 and `mem_read_enable` = 0.
  - `mem_address` and `mem_write_data` = 0.
- Outside RESP, all `rvalid`/`rdata` = 0. Non-winning port outputs are always 0.
- Addresses are passed through unmodified. No range checking is done.
- Requester rule: after seeing `gnt`, a requester may change its fields and re-assert `req` in the very next cycle (the RESP cycle) for back-to-back access.

## Timing
- Request seen in IDLE at cycle T:
  - `gnt` at T+1 (ACCESS).
  - Write commits at the end of T+1.
  - `rvalid`/`rdata` at T+2.
- Latency is 2 cycles from accepted request to response.
- Sustained throughput is one access per 2 cycles (ACCESS/RESP alternation).
- A request arriving during ACCESS is not sampled. It is evaluated in the following RESP cycle.
- Simultaneous `req0`/`req1` while one port streams: grants alternate 0,1,0,1,... No port waits more than one access.
- Reset values:
  - State = IDLE; `last` = 1, so port 0 wins the first tie.
  - All `*_q` registers = 0.
  - All outputs = 0.
- Reset asserted in ACCESS: `mem_write_enable` is forced to 0 in that cycle, so no write commits. The response is dropped and the FSM is in IDLE the next cycle.
- Reset asserted in RESP: the pending `rvalid` for that cycle is still emitted (registered). The FSM returns to IDLE and no new request is latched.

## Configuration
- `DMEM_ARB_FIXED_PRIORITY_EN`
  - Defined: fixed priority. Port 0 always wins when both request, and the `last` register is not implemented.
  - Undefined (default): round-robin as described above.
- All other behaviour and timing are identical in both builds.

## Test plan
- Single write then read: port 0 write `addr0`=0x0005, `wdata0`=0xBEEF, then read 0x0005.
  - Write: `gnt0` at T+1, `rvalid0` at T+2 with `rdata0`=0.
  - Read: `rdata0`=0xBEEF with `rvalid0`.
- Tie after reset: `req0`=`req1`=1 in the same cycle.
  - Port 0 is granted first, port 1 second; responses 2 cycles apart.
  - With the macro defined and `req0` held continuously, port 1 is never granted.
- Back-to-back streaming: port 1 issues four reads at 0x0010–0x0013 (preloaded 1,2,3,4), re-requesting in each RESP cycle.
  - `gnt1` every 2 cycles; `rdata1` = 1,2,3,4; no idle cycles between accesses.
- Reset during ACCESS: port 0 write 0x1234 to 0x0020; assert `reset` in the `gnt0` cycle.
  - `mem_write_enable` stays 0; memory at 0x0020 keeps its old value; no `rvalid0`; all outputs 0 the next cycle.
- Interleaved contention: `req0` and `req1` held continuously for 8 accesses.
  - Round-robin build: grants alternate strictly 0,1,0,1,...
  - Memory inputs are 0 in every RESP cycle.

Source files
------------

// File: rtl/data_memory_arbiter.sv
// data_memory_arbiter: shares one single-port data memory between two requesters (ACCESS/RESP pipeline).
// Optional build macro DMEM_ARB_FIXED_PRIORITY_EN selects fixed priority (port 0 wins ties) instead of round-robin.
`default_nettype none

module data_memory_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [15:0] addr0,
  input  logic [15:0] addr1,
  input  logic [15:0] wdata0,
  input  logic [15:0] wdata1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        rvalid0,
  output logic        rvalid1,
  output logic [15:0] rdata0,
  output logic [15:0] rdata1,
  output logic [15:0] mem_address,
  output logic [15:0] mem_write_data,
  output logic        mem_write_enable,
  output logic        mem_read_enable,
  input  logic [15:0] mem_read_data
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t      state;
  logic        we_q;
  logic        port_q;
  logic [15:0] addr_q;
  logic [15:0] wdata_q;
  logic [15:0] rdata_q;
  logic        any_req;
  logic        winner;
  logic        in_access;
  logic        in_resp;

`ifdef DMEM_ARB_FIXED_PRIORITY_EN
  assign winner = ~req0;
`else
  logic last;

  // On a tie the port that did not win most recently goes next.
  assign winner = (req0 & req1) ? ~last : req1;
`endif

  assign any_req = req0 | req1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      we_q    <= 1'b0;
      port_q  <= 1'b0;
      addr_q  <= 16'h0000;
      wdata_q <= 16'h0000;
      rdata_q <= 16'h0000;
`ifndef DMEM_ARB_FIXED_PRIORITY_EN
      last    <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE, RESP: begin
          if (any_req) begin
            state   <= ACCESS;
            port_q  <= winner;
            we_q    <= winner ? we1 : we0;
            addr_q  <= winner ? addr1 : addr0;
            wdata_q <= winner ? wdata1 : wdata0;
`ifndef DMEM_ARB_FIXED_PRIORITY_EN
            last    <= winner;
`endif
          end else begin
            state <= IDLE;
          end
        end
        ACCESS: begin
          rdata_q <= we_q ? 16'h0000 : mem_read_data;
          state   <= RESP;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_access = (state == ACCESS);
  assign in_resp   = (state == RESP);

  assign gnt0    = in_access & ~port_q;
  assign gnt1    = in_access & port_q;
  assign rvalid0 = in_resp & ~port_q;
  assign rvalid1 = in_resp & port_q;
  assign rdata0  = rvalid0 ? rdata_q : 16'h0000;
  assign rdata1  = rvalid1 ? rdata_q : 16'h0000;

  // The write strobe is gated by reset so an access interrupted by reset never commits.
  assign mem_address      = in_access ? addr_q : 16'h0000;
  assign mem_write_data   = in_access ? wdata_q : 16'h0000;
  assign mem_write_enable = in_access & we_q & ~reset;
  assign mem_read_enable  = in_access & ~we_q;

endmodule

`default_nettype wire

// File: tb/tb_data_memory_arbiter.sv
// tb_data_memory_arbiter: directed steps plus a randomized phase checked against a transaction-level model.
// Expectations for ties follow DMEM_ARB_FIXED_PRIORITY_EN when the bench is built with it.
`default_nettype none

module tb_data_memory_arbiter;

`ifdef DMEM_ARB_FIXED_PRIORITY_EN
  localparam bit FIXED_PRIO = 1'b1;
`else
  localparam bit FIXED_PRIO = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1, we0, we1;
  logic [15:0] addr0, addr1, wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1;
  logic [15:0] rdata0, rdata1;
  logic [15:0] mem_address, mem_write_data, mem_read_data;
  logic        mem_write_enable, mem_read_enable;

  logic [15:0] dev_mem [0:65535] = '{default: 16'h0000};
  logic [69:0] outs;

  int n_asserts = 0;
  int n_fail    = 0;

  data_memory_arbiter dut (
    .clk              (clk),
    .reset            (reset),
    .req0             (req0),
    .req1             (req1),
    .we0              (we0),
    .we1              (we1),
    .addr0            (addr0),
    .addr1            (addr1),
    .wdata0           (wdata0),
    .wdata1           (wdata1),
    .gnt0             (gnt0),
    .gnt1             (gnt1),
    .rvalid0          (rvalid0),
    .rvalid1          (rvalid1),
    .rdata0           (rdata0),
    .rdata1           (rdata1),
    .mem_address      (mem_address),
    .mem_write_data   (mem_write_data),
    .mem_write_enable (mem_write_enable),
    .mem_read_enable  (mem_read_enable),
    .mem_read_data    (mem_read_data)
  );

  initial forever #5 clk = ~clk;

  // Single-port memory with combinational read, driven only by the arbiter.
  always @(posedge clk) begin
    if (mem_write_enable) dev_mem[mem_address] <= mem_write_data;
  end
  assign mem_read_data = dev_mem[mem_address];

  assign outs = {gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
                 mem_address, mem_write_data, mem_write_enable, mem_read_enable};

  function automatic logic [69:0] pk(input logic g0, g1, v0, v1,
                                     input logic [15:0] rd0, rd1, a, d,
                                     input logic we, re);
    return {g0, g1, v0, v1, rd0, rd1, a, d, we, re};
  endfunction

  task automatic chk(input string tag, input logic [69:0] obs, input logic [69:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic p, r, we, input logic [15:0] a, d);
    if (!p) begin
      req0 = r; we0 = we; addr0 = a; wdata0 = d;
    end else begin
      req1 = r; we1 = we; addr1 = a; wdata1 = d;
    end
  endtask

  // One complete access: request now, expect the grant next cycle and the response one cycle later.
  task automatic access(input string tag, input logic p, we, input logic [15:0] a, d, exp_rd);
    drive(p, 1'b1, we, a, d);
    @(negedge clk);
    chk({tag, "_gnt"}, outs, pk(!p, p, 1'b0, 1'b0, 16'h0, 16'h0, a, d, we, !we));
    drive(p, 1'b0, we, a, d);
    @(negedge clk);
    chk({tag, "_resp"}, outs, pk(1'b0, 1'b0, !p, p, p ? 16'h0 : exp_rd, p ? exp_rd : 16'h0,
                                 16'h0, 16'h0, 1'b0, 1'b0));
  endtask

  task automatic reset_pulse();
    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Transaction-level model state for the randomized phase.
  logic        pend   [2];
  logic        f_we   [2];
  logic [15:0] f_addr [2];
  logic [15:0] f_wd   [2];
  logic [15:0] ref_mem [16];
  int          acc_port, rv_port, nxt_acc, nxt_rv;
  logic        acc_we, m_last, w, ew;
  logic [15:0] acc_a, acc_d, rv_d;

  initial begin
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    drive(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
    @(negedge clk);
    @(negedge clk);
    chk("reset_outputs", outs, 70'h0);
    reset = 1'b0;

    // Single write then read on port 0, back to back.
    access("wr_beef", 1'b0, 1'b1, 16'h0005, 16'hBEEF, 16'h0000);
    access("rd_beef", 1'b0, 1'b0, 16'h0005, 16'h1111, 16'hBEEF);

    // Program loader fills 0x10..0x13, then streams reads with no idle cycles.
    for (int i = 0; i < 4; i++)
      access("preload", 1'b1, 1'b1, 16'h0010 + 16'(i), 16'(i + 1), 16'h0000);
    for (int i = 0; i < 4; i++)
      access("stream", 1'b1, 1'b0, 16'h0010 + 16'(i), 16'h0, 16'(i + 1));

    // Tie right after reset: port 0 first, then port 1.
    reset_pulse();
    drive(1'b0, 1'b1, 1'b0, 16'h0040, 16'h1111);
    drive(1'b1, 1'b1, 1'b0, 16'h0041, 16'h2222);
    @(negedge clk);
    chk("tie_gnt0", outs, pk(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0040, 16'h1111, 1'b0, 1'b1));
    req0 = 1'b0;
    @(negedge clk);
    chk("tie_resp0", outs, pk(1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0));
    @(negedge clk);
    chk("tie_gnt1", outs, pk(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0041, 16'h2222, 1'b0, 1'b1));
    req1 = 1'b0;
    @(negedge clk);
    chk("tie_resp1", outs, pk(1'b0, 1'b0, 1'b0, 1'b1, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0));

    // Reset during ACCESS must suppress the write and the response.
    access("pre_20", 1'b0, 1'b1, 16'h0020, 16'h5555, 16'h0000);
    drive(1'b0, 1'b1, 1'b1, 16'h0020, 16'h1234);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst_access", outs, pk(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0020, 16'h1234, 1'b0, 1'b0));
    req0 = 1'b0;
    @(negedge clk);
    chk("rst_after", outs, 70'h0);
    reset = 1'b0;
    chk("mem20_kept", 70'(dev_mem[16'h0020]), 70'h5555);
    access("rd_20", 1'b0, 1'b0, 16'h0020, 16'h0000, 16'h5555);

    // Continuous contention for 8 accesses.
    reset_pulse();
    drive(1'b0, 1'b1, 1'b1, 16'h0030, 16'hA0A0);
    drive(1'b1, 1'b1, 1'b0, 16'h0010, 16'hC0C0);
    for (int i = 0; i < 8; i++) begin
      ew = FIXED_PRIO ? 1'b0 : 1'(i % 2);
      @(negedge clk);
      chk("contend_gnt", outs, pk(!ew, ew, 1'b0, 1'b0, 16'h0, 16'h0,
                                  ew ? 16'h0010 : 16'h0030, ew ? 16'hC0C0 : 16'hA0A0, !ew, ew));
      @(negedge clk);
      chk("contend_resp", outs, pk(1'b0, 1'b0, !ew, ew, 16'h0, ew ? 16'h0001 : 16'h0000,
                                   16'h0, 16'h0, 1'b0, 1'b0));
    end
    req0 = 1'b0; req1 = 1'b0;

    // Randomized traffic against the transaction-level model, on a memory region untouched so far.
    reset_pulse();
    for (int i = 0; i < 16; i++) ref_mem[i] = 16'h0000;
    for (int p = 0; p < 2; p++) pend[p] = 1'b0;
    acc_port = -1; rv_port = -1; m_last = 1'b1;
    acc_we = 1'b0; acc_a = 16'h0; acc_d = 16'h0; rv_d = 16'h0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      @(negedge clk);
      chk("rand", outs, pk(acc_port == 0, acc_port == 1, rv_port == 0, rv_port == 1,
                           (rv_port == 0) ? rv_d : 16'h0, (rv_port == 1) ? rv_d : 16'h0,
                           (acc_port >= 0) ? acc_a : 16'h0, (acc_port >= 0) ? acc_d : 16'h0,
                           (acc_port >= 0) && acc_we, (acc_port >= 0) && !acc_we));
      nxt_acc = -1; nxt_rv = -1;
      if (acc_port >= 0) begin
        // Granted access completes: response next cycle, requester is free to ask again.
        nxt_rv = acc_port;
        rv_d   = acc_we ? 16'h0 : ref_mem[acc_a[3:0]];
        if (acc_we) ref_mem[acc_a[3:0]] = acc_d;
        pend[acc_port] = 1'b0;
      end
      for (int p = 0; p < 2; p++) begin
        if (!pend[p]) begin
          pend[p]   = ($urandom_range(0, 3) != 0);
          f_we[p]   = 1'($urandom_range(0, 1));
          f_addr[p] = 16'h0100 + 16'($urandom_range(0, 15));
          f_wd[p]   = 16'($urandom);
        end
      end
      if (acc_port < 0 && (pend[0] || pend[1])) begin
        if (pend[0] && pend[1]) w = FIXED_PRIO ? 1'b0 : !m_last;
        else                    w = pend[1];
        nxt_acc = int'(w);
        acc_we  = f_we[w];
        acc_a   = f_addr[w];
        acc_d   = f_wd[w];
        m_last  = w;
      end
      acc_port = nxt_acc;
      rv_port  = nxt_rv;
      drive(1'b0, pend[0], f_we[0], f_addr[0], f_wd[0]);
      drive(1'b1, pend[1], f_we[1], f_addr[1], f_wd[1]);
    end
    req0 = 1'b0; req1 = 1'b0;
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
